btn_conditioner: RTL

//  Input stage in front of the chess-timer control/setTime logic. Synchronises raw

---
 rtl/btn_conditioner_pkg.sv | 35 +++
 rtl/btn_debounce_ch.sv | 150 +++++++++++++++
 rtl/btn_conditioner.sv | 45 ++++
 3 files changed

// File: rtl/btn_conditioner_pkg.sv
// Shared types and default timing constants for the button conditioner.
// The optional auto-repeat feature is selected with the BTN_REPEAT_EN macro.
package btn_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONF_HI = 2'd1,
    ST_PRESSED = 2'd2,
    ST_CONF_LO = 2'd3
  } btn_state_t;

  // Per-channel conditioned outputs, all registered.
  typedef struct packed {
    logic level;
    logic press;
    logic rel;
  } btn_event_t;

  localparam int unsigned DEF_N_BTN         = 4;
  localparam int unsigned DEF_DB_CYCLES     = 1_000_000;
  localparam int unsigned DEF_REPEAT_DELAY  = 50_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD = 20_000_000;

  // Bits needed to count 0..max_count-1; at least one bit.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    int unsigned w;
    w = (max_count <= 32'd1) ? 32'd1 : 32'($clog2(max_count));
    return w;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One conditioner channel: 2-FF synchroniser, debounce FSM, registered events.
// With BTN_REPEAT_EN defined, a hold counter adds auto-repeat presses when REPEAT_EN=1.
module btn_debounce_ch
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter bit          REPEAT_EN     = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output btn_event_t ev
);

  localparam int unsigned CNT_W = cnt_width(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 32'd1);

  if (DB_CYCLES < 1 || (REPEAT_EN && (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1))) begin : g_bad_param
    $error("btn_debounce_ch: DB_CYCLES and active REPEAT_* values must be >= 1");
  end

  logic [1:0]       sync_q;
  logic             s;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_edge, release_edge, level_d, rep_fire;
  btn_event_t       ev_d;

  assign s = sync_q[1];

  // Debounce FSM: next state, confirmation counter and edge events.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    press_edge   = 1'b0;
    release_edge = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (s) begin
          state_d = ST_CONF_HI;
          cnt_d   = '0;
        end
      end
      ST_CONF_HI: begin
        if (!s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d    = ST_PRESSED;
          cnt_d      = '0;
          press_edge = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!s) begin
          state_d = ST_CONF_LO;
          cnt_d   = '0;
        end
      end
      ST_CONF_LO: begin
        if (s) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d      = ST_IDLE;
          cnt_d        = '0;
          release_edge = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_d = (state_d == ST_PRESSED) || (state_d == ST_CONF_LO);

`ifdef BTN_REPEAT_EN
  localparam int unsigned HOLD_W = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [HOLD_W-1:0] DELAY_MAX  = HOLD_W'(REPEAT_DELAY - 32'd1);
  localparam logic [HOLD_W-1:0] PERIOD_MAX = HOLD_W'(REPEAT_PERIOD - 32'd1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              in_period_q, in_period_d;

  // Hold counter: initial delay after a press, then fixed period; resumes period after a glitch.
  always_comb begin
    hold_d      = hold_q;
    in_period_d = in_period_q;
    rep_fire    = 1'b0;
    if (REPEAT_EN) begin
      if (state_q == ST_PRESSED && state_d == ST_PRESSED) begin
        if (hold_q == (in_period_q ? PERIOD_MAX : DELAY_MAX)) begin
          rep_fire    = 1'b1;
          hold_d      = '0;
          in_period_d = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end else if (state_d != state_q) begin
        hold_d = '0;
        if (state_q == ST_CONF_HI) begin
          in_period_d = 1'b0;
        end else if (state_q == ST_CONF_LO && state_d == ST_PRESSED) begin
          in_period_d = 1'b1;
        end else if (state_d == ST_IDLE) begin
          in_period_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q      <= '0;
      in_period_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      in_period_q <= in_period_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign ev_d = '{level: level_d, press: press_edge | rep_fire, rel: release_edge};

  // Synchroniser, FSM state, counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ev      <= '0;
    end else begin
      sync_q  <= {sync_q[0], din};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ev      <= ev_d;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Debounces N_BTN raw buttons into clean levels and one-cycle press/release pulses.
// Define BTN_REPEAT_EN to enable auto-repeat on channels selected by REPEAT_MASK.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned          N_BTN         = DEF_N_BTN,
  parameter int unsigned          DB_CYCLES     = DEF_DB_CYCLES,
  parameter int unsigned          REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned          REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter logic [N_BTN-1:0]     REPEAT_MASK   = N_BTN'(4'b1000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  if (N_BTN < 1) begin : g_bad_n
    $error("btn_conditioner: N_BTN must be >= 1");
  end

  // Channels are fully independent; each gets its own auto-repeat enable bit.
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_event_t ev;

    btn_debounce_ch #(
      .DB_CYCLES    (DB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .REPEAT_EN    (REPEAT_MASK[i])
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .din  (btn_in[i]),
      .ev   (ev)
    );

    assign btn_level[i]   = ev.level;
    assign btn_press[i]   = ev.press;
    assign btn_release[i] = ev.rel;
  end

endmodule
